// File: rtl/shift_pkg.sv
// Shared FSM encodings and datapath width for the shift arbiter.
package shift_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/xyz.sv
// 16-bit combinational barrel shifter core: left, logical right, arithmetic right.
// No state and no latency; the result follows the inputs in the same cycle.
module xyz (
  input  logic [15:0] data,
  input  logic [3:0]  amt,
  input  logic        dir,
  input  logic        arith,
  output logic [15:0] result
);

  always_comb begin
    result = data;
    if (!dir) begin
      result = data << amt;
    end else if (arith) begin
      result = $unsigned($signed(data) >>> amt);
    end else begin
      result = data >> amt;
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester arbiter in front of the xyz shifter: accept -> result valid in 2 cycles.
// Ready is offered only in IDLE; the result is held in DONE until res_ready.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [DATA_W-1:0] r0_data,
  input  logic [3:0]        r0_amt,
  input  logic              r0_dir,
  input  logic              r0_arith,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [DATA_W-1:0] r1_data,
  input  logic [3:0]        r1_amt,
  input  logic              r1_dir,
  input  logic              r1_arith,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_id
);

  state_t            state;
  state_t            state_nxt;
  logic              last_grant;
  logic              grant_vld;
  logic              grant_id;
  logic              accept;
  logic [DATA_W-1:0] op_data;
  logic [3:0]        op_amt;
  logic              op_dir;
  logic              op_arith;
  logic              op_id;
  logic [DATA_W-1:0] shift_res;

  // A lone requester always wins; only a tie consults last_grant in RR mode.
  always_comb begin
    grant_vld = r0_valid | r1_valid;
    if ((RR_EN != 0) && r0_valid && r1_valid) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = ~r0_valid;
    end
  end

  assign accept   = (state == IDLE) && grant_vld;
  assign r0_ready = accept && !grant_id;
  assign r1_ready = accept && grant_id;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_data    <= '0;
      op_amt     <= '0;
      op_dir     <= 1'b0;
      op_arith   <= 1'b0;
      op_id      <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      op_data    <= grant_id ? r1_data  : r0_data;
      op_amt     <= grant_id ? r1_amt   : r0_amt;
      op_dir     <= grant_id ? r1_dir   : r0_dir;
      op_arith   <= grant_id ? r1_arith : r0_arith;
      op_id      <= grant_id;
      last_grant <= grant_id;
    end
  end

  xyz u_core (
    .data   (op_data),
    .amt    (op_amt),
    .dir    (op_dir),
    .arith  (op_arith),
    .result (shift_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= 1'b0;
    end else if (state == EXEC) begin
      res_valid <= 1'b1;
      res_data  <= shift_res;
      res_id    <= op_id;
    end else if ((state == DONE) && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: vector table of shifts plus contention, backpressure and reset sequences.
module tb_shift_arbiter;

  logic        clk;
  logic        rst_n;
  logic        r0_valid, r0_dir, r0_arith;
  logic [15:0] r0_data;
  logic [3:0]  r0_amt;
  logic        r1_valid, r1_dir, r1_arith;
  logic [15:0] r1_data;
  logic [3:0]  r1_amt;
  logic        res_ready;

  logic        r0_ready, r1_ready, res_valid, res_id;
  logic [15:0] res_data;
  logic        r0_ready_fp, r1_ready_fp, res_valid_fp, res_id_fp;
  logic [15:0] res_data_fp;

  int errors = 0;
  int checks = 0;

  shift_arbiter #(.RR_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_data(r0_data),
    .r0_amt(r0_amt), .r0_dir(r0_dir), .r0_arith(r0_arith),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_data(r1_data),
    .r1_amt(r1_amt), .r1_dir(r1_dir), .r1_arith(r1_arith),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id)
  );

  shift_arbiter #(.RR_EN(0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready_fp), .r0_data(r0_data),
    .r0_amt(r0_amt), .r0_dir(r0_dir), .r0_arith(r0_arith),
    .r1_valid(r1_valid), .r1_ready(r1_ready_fp), .r1_data(r1_data),
    .r1_amt(r1_amt), .r1_dir(r1_dir), .r1_arith(r1_arith),
    .res_valid(res_valid_fp), .res_ready(res_ready),
    .res_data(res_data_fp), .res_id(res_id_fp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        id;
    logic [15:0] data;
    logic [3:0]  amt;
    logic        dir;
    logic        arith;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_r0(input logic [15:0] d, input logic [3:0] a, input logic dr, input logic ar);
    r0_data = d; r0_amt = a; r0_dir = dr; r0_arith = ar; r0_valid = 1'b1;
  endtask

  task automatic set_r1(input logic [15:0] d, input logic [3:0] a, input logic dr, input logic ar);
    r1_data = d; r1_amt = a; r1_dir = dr; r1_arith = ar; r1_valid = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Entered and left one time unit after a rising edge with the DUT in IDLE.
  task automatic run_vec(input vec_t v);
    if (v.id) set_r1(v.data, v.amt, v.dir, v.arith);
    else      set_r0(v.data, v.amt, v.dir, v.arith);
    res_ready = 1'b1;
    @(negedge clk);
    chk1("vec_r0_ready", r0_ready, !v.id);
    chk1("vec_r1_ready", r1_ready, v.id);
    next_cycle();
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    @(negedge clk);
    chk1("vec_exec_res_valid", res_valid, 1'b0);
    next_cycle();
    @(negedge clk);
    chk1("vec_res_valid", res_valid, 1'b1);
    chk16("vec_res_data", res_data, v.exp);
    chk1("vec_res_id", res_id, v.id);
    next_cycle();
  endtask

  initial begin
    vecs[0] = '{1'b0, 16'h8001, 4'd4,  1'b1, 1'b1, 16'hF800};
    vecs[1] = '{1'b0, 16'hFFFF, 4'd15, 1'b0, 1'b0, 16'h8000};
    vecs[2] = '{1'b0, 16'h1234, 4'd0,  1'b1, 1'b1, 16'h1234};
    vecs[3] = '{1'b0, 16'h8000, 4'd15, 1'b1, 1'b0, 16'h0001};
    vecs[4] = '{1'b1, 16'h1234, 4'd4,  1'b0, 1'b1, 16'h2340};
    vecs[5] = '{1'b0, 16'h8000, 4'd15, 1'b1, 1'b1, 16'hFFFF};
    vecs[6] = '{1'b1, 16'h00F0, 4'd4,  1'b1, 1'b0, 16'h000F};
    vecs[7] = '{1'b0, 16'h7FFF, 4'd1,  1'b1, 1'b1, 16'h3FFF};
    vecs[8] = '{1'b0, 16'h0001, 4'd15, 1'b0, 1'b0, 16'h8000};
    vecs[9] = '{1'b1, 16'hA5A5, 4'd8,  1'b1, 1'b1, 16'hFFA5};

    rst_n = 1'b0;
    r0_valid = 1'b0; r0_data = '0; r0_amt = '0; r0_dir = 1'b0; r0_arith = 1'b0;
    r1_valid = 1'b0; r1_data = '0; r1_amt = '0; r1_dir = 1'b0; r1_arith = 1'b0;
    res_ready = 1'b0;

    @(negedge clk);
    chk1("rst_res_valid", res_valid, 1'b0);
    chk16("rst_res_data", res_data, 16'h0000);
    chk1("rst_res_id", res_id, 1'b0);
    chk1("rst_r0_ready", r0_ready, 1'b0);
    chk1("rst_r1_ready", r1_ready, 1'b0);
    next_cycle();
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Contention from reset: RR alternates 0,1,0,1; fixed priority always picks 0.
    rst_n = 1'b0;
    repeat (2) next_cycle();
    rst_n = 1'b1;
    set_r0(16'h0011, 4'd1, 1'b0, 1'b0);
    set_r1(16'h0100, 4'd4, 1'b1, 1'b0);
    res_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      logic acc_cyc;
      logic g;
      acc_cyc = (c % 3) == 0;
      g = ((c / 3) % 2) == 1;
      @(negedge clk);
      chk1("rr_r0_ready", r0_ready, acc_cyc && !g);
      chk1("rr_r1_ready", r1_ready, acc_cyc && g);
      chk1("fp_r0_ready", r0_ready_fp, acc_cyc);
      chk1("fp_r1_ready", r1_ready_fp, 1'b0);
      if ((c % 3) == 2) begin
        chk1("rr_res_valid", res_valid, 1'b1);
        chk1("rr_res_id", res_id, g);
        chk16("rr_res_data", res_data, g ? 16'h0010 : 16'h0022);
        chk1("fp_res_id", res_id_fp, 1'b0);
        chk16("fp_res_data", res_data_fp, 16'h0022);
      end
      next_cycle();
    end
    r0_valid = 1'b0;
    r1_valid = 1'b0;

    // Backpressure: result held for 5 cycles while r1 keeps waiting.
    set_r0(16'h8001, 4'd4, 1'b1, 1'b1);
    set_r1(16'h0F00, 4'd4, 1'b0, 1'b0);
    res_ready = 1'b0;
    @(negedge clk);
    chk1("bp_accept_r0", r0_ready, 1'b1);
    chk1("bp_accept_r1", r1_ready, 1'b0);
    next_cycle();
    r0_valid = 1'b0;
    @(negedge clk);
    chk1("bp_exec_r1_ready", r1_ready, 1'b0);
    chk1("bp_exec_res_valid", res_valid, 1'b0);
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk1("bp_hold_res_valid", res_valid, 1'b1);
      chk16("bp_hold_res_data", res_data, 16'hF800);
      chk1("bp_hold_res_id", res_id, 1'b0);
      chk1("bp_hold_r0_ready", r0_ready, 1'b0);
      chk1("bp_hold_r1_ready", r1_ready, 1'b0);
      next_cycle();
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk1("bp_release_res_valid", res_valid, 1'b1);
    chk1("bp_release_r1_ready", r1_ready, 1'b0);
    next_cycle();
    @(negedge clk);
    chk1("bp_next_r1_ready", r1_ready, 1'b1);
    chk1("bp_next_res_valid", res_valid, 1'b0);
    next_cycle();
    r1_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    chk1("bp_r1_res_valid", res_valid, 1'b1);
    chk16("bp_r1_res_data", res_data, 16'hF000);
    chk1("bp_r1_res_id", res_id, 1'b1);
    next_cycle();

    // Reset pulse in EXEC after an r0 grant: the next tie must go to r0 again.
    set_r0(16'h00FF, 4'd4, 1'b0, 1'b0);
    @(negedge clk);
    chk1("mid_accept_r0", r0_ready, 1'b1);
    next_cycle();
    r0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_res_valid", res_valid, 1'b0);
    #1;
    rst_n = 1'b1;
    set_r0(16'h0003, 4'd2, 1'b0, 1'b0);
    set_r1(16'h0100, 4'd1, 1'b0, 1'b0);
    #1;
    chk1("mid_post_r0_ready", r0_ready, 1'b1);
    chk1("mid_post_r1_ready", r1_ready, 1'b0);
    next_cycle();
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    @(negedge clk);
    chk1("mid_exec_res_valid", res_valid, 1'b0);
    next_cycle();
    @(negedge clk);
    chk1("mid_res_valid", res_valid, 1'b1);
    chk16("mid_res_data", res_data, 16'h000C);
    chk1("mid_res_id", res_id, 1'b0);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
